// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: serial-in/parallel-out capture stage with a valid/ack handshake.
// A frame starts on S. D is sampled on every rising C until WIDTH data bits
// have been collected. The word is then held on Q with VLD until ACK.
// Optional build macro SIPO_PARITY_EN: each frame carries one extra even-parity
// bit after the data bits. A mismatch is flagged on ERR alongside VLD.
// Without the macro, ERR is constant 0. The port list is the same in both builds.
module sipo_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             C,
   input  logic             nR,
   input  logic             D,
   input  logic             S,
   input  logic             ACK,
   output logic [WIDTH-1:0] Q,
   output logic             VLD,
   output logic             BUSY,
   output logic             ERR
);

`ifdef SIPO_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CW     = $clog2(NBITS + 1);
   // A one-bit frame completes on the same edge that sees S.
   localparam bit SINGLE = (NBITS == 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_next;
   logic [WIDTH-1:0] final_word;
   logic             final_err;
   logic             start_frame;
   logic             last_bit;

   // Shifter input: the new D bit enters at the end selected by the bit order.
   generate
      if (WIDTH == 1) begin : g_w1
         assign shift_next = D;
      end else if (MSB_FIRST) begin : g_msb
         assign shift_next = {shift_reg[WIDTH-2:0], D};
      end else begin : g_lsb
         assign shift_next = {D, shift_reg[WIDTH-1:1]};
      end
   endgenerate

`ifdef SIPO_PARITY_EN
   // The final sampled bit is parity. It is checked but never shifted into the word.
   assign final_word = shift_reg;
   assign final_err  = (^shift_reg) ^ D;
`else
   // The final sampled bit is the last data bit. It completes the word directly.
   assign final_word = shift_next;
   assign final_err  = 1'b0;
`endif

   // A new frame may begin from IDLE, or from HOLD when the held word is acknowledged.
   assign start_frame = S && ((state_reg == IDLE) || ((state_reg == HOLD) && ACK));
   assign last_bit    = (cnt_reg == CW'(NBITS - 1));

   // Frame FSM. All outputs are registered. Q keeps its last word until the next frame completes.
   always_ff @(posedge C or negedge nR) begin
      if (!nR) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         shift_reg <= '0;
         Q         <= '0;
         VLD       <= 1'b0;
         BUSY      <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         case (state_reg)
            SHIFT: begin
               if (last_bit) begin
                  Q         <= final_word;
                  ERR       <= final_err;
                  VLD       <= 1'b1;
                  BUSY      <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= HOLD;
               end else begin
                  shift_reg <= shift_next;
                  cnt_reg   <= cnt_reg + CW'(1);
               end
            end
            HOLD: begin
               // Without ACK the held word is protected: S and D are ignored.
               if (ACK) begin
                  VLD       <= 1'b0;
                  ERR       <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase

         // Frame start overrides the IDLE/HOLD assignments made above.
         if (start_frame) begin
            if (SINGLE) begin
               Q         <= final_word;
               ERR       <= final_err;
               VLD       <= 1'b1;
               state_reg <= HOLD;
            end else begin
               shift_reg <= shift_next;
               cnt_reg   <= CW'(1);
               BUSY      <= 1'b1;
               state_reg <= SHIFT;
            end
         end
      end
   end

endmodule

// File: tb/tb_sipo_shift_reg.sv
// tb_sipo_shift_reg: directed bench for sipo_shift_reg at WIDTH=8.
// Two instances share the same inputs: one is MSB-first and one is LSB-first.
// The bench follows SIPO_PARITY_EN when that macro is defined for the build.
module tb_sipo_shift_reg;

`ifdef SIPO_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic       C;
   logic       nR;
   logic       D;
   logic       S;
   logic       ACK;
   logic [7:0] q_m;
   logic [7:0] q_l;
   logic       vld_m, busy_m, err_m;
   logic       vld_l, busy_l, err_l;

   int checks = 0;
   int errors = 0;

   sipo_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .C(C), .nR(nR), .D(D), .S(S), .ACK(ACK),
      .Q(q_m), .VLD(vld_m), .BUSY(busy_m), .ERR(err_m)
   );

   sipo_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .C(C), .nR(nR), .D(D), .S(S), .ACK(ACK),
      .Q(q_l), .VLD(vld_l), .BUSY(busy_l), .ERR(err_l)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one set of inputs and advance one rising edge. Outputs are read 1 ns later.
   task automatic step(input logic d, input logic s, input logic ack);
      D   = d;
      S   = s;
      ACK = ack;
      @(posedge C);
      #1;
   endtask

   // Send one frame whose first bit is bits[7]. When parity is enabled, append par_bit.
   // BUSY/VLD are checked on every edge, and the held word is checked at the end.
   task automatic frame(input string tag, input logic [7:0] bits, input logic ack_first,
                        input logic par_bit);
      int total;
      total = PAR ? 9 : 8;
      for (int i = 0; i < total; i++) begin
         step((i < 8) ? bits[7-i] : par_bit, (i == 0), (i == 0) ? ack_first : 1'b0);
         if (i < total - 1) begin
            chk({tag, " busy mid"}, {31'd0, busy_m}, 32'd1);
            chk({tag, " vld mid"},  {31'd0, vld_m},  32'd0);
         end
      end
      chk({tag, " vld end"},  {31'd0, vld_m},  32'd1);
      chk({tag, " busy end"}, {31'd0, busy_m}, 32'd0);
      $display("frame %s: bits=%02h q_msb=%02h q_lsb=%02h err=%0b", tag, bits, q_m, q_l, err_m);
   endtask

   initial begin
      nR  = 1'b0;
      D   = 1'b0;
      S   = 1'b0;
      ACK = 1'b0;
      #2;
      chk("reset q",    {24'd0, q_m},    32'h0);
      chk("reset vld",  {31'd0, vld_m},  32'd0);
      chk("reset busy", {31'd0, busy_m}, 32'd0);
      chk("reset err",  {31'd0, err_m},  32'd0);
      #2 nR = 1'b1;

      // D without S is ignored in IDLE.
      step(1'b1, 1'b0, 1'b0);
      chk("idle no start", {31'd0, busy_m}, 32'd0);

      // 1) 0xA5, MSB first.
      frame("a5", 8'hA5, 1'b0, 1'b0);
      chk("a5 q msb", {24'd0, q_m}, 32'hA5);
      chk("a5 q lsb", {24'd0, q_l}, 32'hA5);
      chk("a5 err",   {31'd0, err_m}, 32'd0);

      // 2) Hold with ACK=0 while S pulses and D toggles. Then acknowledge.
      for (int i = 0; i < 5; i++) begin
         step(i[0], ~i[0], 1'b0);
         chk("hold q",   {24'd0, q_m},   32'hA5);
         chk("hold vld", {31'd0, vld_m}, 32'd1);
      end
      step(1'b0, 1'b0, 1'b1);
      chk("ack vld",  {31'd0, vld_m},  32'd0);
      chk("ack q kept", {24'd0, q_m},  32'hA5);
      step(1'b1, 1'b0, 1'b0);
      chk("idle busy", {31'd0, busy_m}, 32'd0);
      chk("idle vld",  {31'd0, vld_m},  32'd0);

      // 3) Fill HOLD, then start a back-to-back frame 0x3C.
      frame("81", 8'h81, 1'b0, 1'b0);
      chk("81 q msb", {24'd0, q_m}, 32'h81);
      frame("3c", 8'h3C, 1'b1, 1'b0);
      chk("3c q msb", {24'd0, q_m}, 32'h3C);
      chk("3c q lsb", {24'd0, q_l}, 32'h3C);

      // 4) Bit order: first bit 1 lands in the MSB for one instance and the LSB for the other.
      frame("80", 8'h80, 1'b1, 1'b1);
      chk("order msb", {24'd0, q_m}, 32'h80);
      chk("order lsb", {24'd0, q_l}, 32'h01);
      chk("order vld lsb", {31'd0, vld_l}, 32'd1);

      // 5) Reset mid-frame, then a clean 0xFF frame.
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("pre-reset busy", {31'd0, busy_m}, 32'd1);
      #1 nR = 1'b0;
      #1;
      chk("mid reset q",    {24'd0, q_m},    32'h0);
      chk("mid reset vld",  {31'd0, vld_m},  32'd0);
      chk("mid reset busy", {31'd0, busy_m}, 32'd0);
      chk("mid reset busy lsb", {31'd0, busy_l}, 32'd0);
      nR = 1'b1;
      frame("ff", 8'hFF, 1'b0, 1'b0);
      chk("ff q msb", {24'd0, q_m}, 32'hFF);
      chk("ff q lsb", {24'd0, q_l}, 32'hFF);
      step(1'b0, 1'b0, 1'b1);

      // 6) Send the 9-bit stream 0xA5 plus a parity bit.
      if (PAR) begin
         frame("a5p0", 8'hA5, 1'b0, 1'b0);
         chk("par ok q",   {24'd0, q_m},   32'hA5);
         chk("par ok err", {31'd0, err_m}, 32'd0);
         step(1'b0, 1'b0, 1'b1);
         frame("a5p1", 8'hA5, 1'b0, 1'b1);
         chk("par bad q",   {24'd0, q_m},   32'hA5);
         chk("par bad err", {31'd0, err_m}, 32'd1);
         step(1'b0, 1'b0, 1'b1);
         chk("par ack err", {31'd0, err_m}, 32'd0);
      end else begin
         frame("a5np", 8'hA5, 1'b0, 1'b0);
         chk("nopar q",   {24'd0, q_m},   32'hA5);
         chk("nopar err", {31'd0, err_m}, 32'd0);
         step(1'b1, 1'b0, 1'b0);
         chk("nopar 9th q",   {24'd0, q_m},   32'hA5);
         chk("nopar 9th err", {31'd0, err_m}, 32'd0);
         chk("nopar 9th vld", {31'd0, vld_m}, 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
